qsys_led_fader: RTL and testbench

- Avalon-ST RGB colour source that sits directly upstream of the FuncLED PWM block.
- Drives that block's 24-bit {R,G,B} stream input.
- Produces linear per-channel fades from COLOR_A to COLOR_B: either a one-shot fade or a continuous A<->B "breathe".
- Configured by a CPU over Avalon-MM; raises an optional interrupt when an endpoint is reached.

---
 rtl/qsys_led_fader.sv | 175 +++++++++++++++++
 tb/tb_qsys_led_fader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_led_fader.sv
// Avalon-ST RGB fade source with CPU control, feeding the FuncLED PWM stream.
// Latency: first beat the cycle after EN is set; beats max(PERIOD,1)+1 cycles apart.
// Backpressure: EMIT holds the current colour until ready; no step happens while a beat is pending.
//
// Ports:
//   csi_MCLK_clk / rsi_MRST_reset : clock, asynchronous active-high reset
//   avs_CTRL_*                    : Avalon-MM register slave (CTRL, COLOR_B, COLOR_A, PERIOD)
//   aso_LEDS_*                    : Avalon-ST 24-bit {R,G,B} source
//   ins_IRQ_irq                   : level interrupt, DONE & IRQ_EN (registered)
module qsys_led_fader #(
  parameter int PRESCALE_W = 24
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [1:0]  avs_CTRL_address,
  input  logic [31:0] avs_CTRL_writedata,
  output logic [31:0] avs_CTRL_readdata,
  input  logic [3:0]  avs_CTRL_byteenable,
  input  logic        avs_CTRL_write,
  input  logic        avs_CTRL_read,
  output logic        avs_CTRL_waitrequest,
  output logic [23:0] aso_LEDS_data,
  output logic        aso_LEDS_valid,
  input  logic        aso_LEDS_ready,
  output logic        ins_IRQ_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    en_q, mode_q, irq_en_q, done_q, irq_q;
  logic [23:0]             color_a_q, color_b_q, cur_q;
  logic [PRESCALE_W-1:0]   period_q, pcnt_q;
  logic                    dest_sel_q;

  // Per-byte merge of a write into a register's current value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // One channel moves one code toward its target; it can never overshoot or wrap.
  function automatic logic [7:0] step8(input logic [7:0] c, input logic [7:0] d);
    if (c < d)      return c + 8'd1;
    else if (c > d) return c - 8'd1;
    else            return c;
  endfunction

  logic wr_ctrl, wr_b, wr_a, wr_per;
  logic en_set, en_clr, done_w1c;
  logic [31:0] color_a_mrg, color_b_mrg, period_mrg;
  logic [23:0] dest, cur_step;
  logic [PRESCALE_W-1:0] period_eff;
  logic pcnt_last;

  assign wr_ctrl  = avs_CTRL_write && (avs_CTRL_address == 2'd0);
  assign wr_b     = avs_CTRL_write && (avs_CTRL_address == 2'd1);
  assign wr_a     = avs_CTRL_write && (avs_CTRL_address == 2'd2);
  assign wr_per   = avs_CTRL_write && (avs_CTRL_address == 2'd3);
  assign en_set   = wr_ctrl && avs_CTRL_byteenable[0] &&  avs_CTRL_writedata[0];
  assign en_clr   = wr_ctrl && avs_CTRL_byteenable[0] && !avs_CTRL_writedata[0];
  assign done_w1c = wr_ctrl && avs_CTRL_byteenable[1] &&  avs_CTRL_writedata[8];

  assign color_a_mrg = be_merge({8'd0, color_a_q}, avs_CTRL_writedata, avs_CTRL_byteenable);
  assign color_b_mrg = be_merge({8'd0, color_b_q}, avs_CTRL_writedata, avs_CTRL_byteenable);
  assign period_mrg  = be_merge(32'(period_q), avs_CTRL_writedata, avs_CTRL_byteenable);

  // Destination is read live so a colour write retargets the fade at the next step.
  assign dest       = dest_sel_q ? color_a_q : color_b_q;
  assign cur_step   = {step8(cur_q[23:16], dest[23:16]),
                       step8(cur_q[15:8],  dest[15:8]),
                       step8(cur_q[7:0],   dest[7:0])};
  // PERIOD of 0 behaves as 1 so the prescaler always terminates.
  assign period_eff = (period_q == '0) ? PRESCALE_W'(1) : period_q;
  assign pcnt_last  = (pcnt_q == period_eff - PRESCALE_W'(1));

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      color_a_q  <= '0;
      color_b_q  <= '0;
      cur_q      <= '0;
      period_q   <= '0;
      pcnt_q     <= '0;
      dest_sel_q <= 1'b0;
    end else begin
      if (wr_a)   color_a_q <= color_a_mrg[23:0];
      if (wr_b)   color_b_q <= color_b_mrg[23:0];
      if (wr_per) period_q  <= period_mrg[PRESCALE_W-1:0];
      if (wr_ctrl && avs_CTRL_byteenable[0]) begin
        en_q     <= avs_CTRL_writedata[0];
        mode_q   <= avs_CTRL_writedata[1];
        irq_en_q <= avs_CTRL_writedata[2];
      end
      // Clear first; an endpoint reached in the same cycle overrides below.
      if (done_w1c) done_q <= 1'b0;
      irq_q <= done_q && irq_en_q;

      if (en_clr) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_FIN: begin
            if (en_set) begin
              cur_q      <= color_a_q;
              dest_sel_q <= 1'b0;
              state_q    <= ST_EMIT;
            end
          end
          ST_EMIT: begin
            if (aso_LEDS_ready) begin
              pcnt_q <= '0;
              if (cur_q == dest) begin
                done_q <= 1'b1;
                if (mode_q) begin
                  dest_sel_q <= !dest_sel_q;
                  state_q    <= ST_RUN;
                end else begin
                  state_q <= ST_FIN;
                end
              end else begin
                state_q <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (pcnt_last) begin
              cur_q   <= cur_step;
              state_q <= ST_EMIT;
            end else begin
              pcnt_q <= pcnt_q + PRESCALE_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    avs_CTRL_readdata = 32'd0;
    case (avs_CTRL_address)
      2'd0: avs_CTRL_readdata = {14'd0, state_q, 7'd0, done_q, 5'd0, irq_en_q, mode_q, en_q};
      2'd1: avs_CTRL_readdata = {8'd0, color_b_q};
      2'd2: avs_CTRL_readdata = {8'd0, color_a_q};
      2'd3: avs_CTRL_readdata = 32'(period_q);
      default: avs_CTRL_readdata = 32'd0;
    endcase
  end

  assign avs_CTRL_waitrequest = rsi_MRST_reset;
  assign aso_LEDS_data        = cur_q;
  assign aso_LEDS_valid       = (state_q == ST_EMIT);
  assign ins_IRQ_irq          = irq_q;

  // Reads have no side effects; upper merge bytes are don't-care.
  logic unused_ok;
  assign unused_ok = ^{avs_CTRL_read, color_a_mrg, color_b_mrg, period_mrg};

endmodule

// File: tb/tb_qsys_led_fader.sv
module tb_qsys_led_fader;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        wr, rd;
  logic        waitreq;
  logic [23:0] ldata;
  logic        lvalid, lready;
  logic        irq;

  qsys_led_fader #(.PRESCALE_W(24)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_CTRL_address     (addr),
    .avs_CTRL_writedata   (wdata),
    .avs_CTRL_readdata    (rdata),
    .avs_CTRL_byteenable  (be),
    .avs_CTRL_write       (wr),
    .avs_CTRL_read        (rd),
    .avs_CTRL_waitrequest (waitreq),
    .aso_LEDS_data        (ldata),
    .aso_LEDS_valid       (lvalid),
    .aso_LEDS_ready       (lready),
    .ins_IRQ_irq          (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] dat;
    int          gap;   // expected cycles since previous handshake, 0 = unchecked
  } beat_t;
  beat_t exp_q[$];
  int last_hs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input int gap);
    beat_t b;
    b.dat = d;
    b.gap = gap;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && lvalid && lready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got %h expected none", ldata);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_data", {8'd0, ldata}, {8'd0, b.dat});
        if (b.gap != 0) chk("beat_gap", cyc - last_hs, b.gap);
      end
      last_hs = cyc;
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; be = 4'h0;
  endtask

  task automatic bus_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a; rd = 1'b1;
    #1;
    chk(name, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!lvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, lvalid}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; addr = 2'd0; wdata = '0; be = 4'h0; wr = 1'b0; rd = 1'b0; lready = 1'b1;

    // Reset behaviour
    repeat (5) @(negedge clk);
    chk("rst_valid", {31'd0, lvalid}, 32'd0);
    chk("rst_data", {8'd0, ldata}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_waitreq", {31'd0, waitreq}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("waitreq_after", {31'd0, waitreq}, 32'd0);
    bus_rd("ctrl_after_rst", 2'd0, 32'h0);

    // Register readback, byte enables, unused bits
    bus_wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    bus_rd("period_rb", 2'd3, 32'h00FF_FFFF);
    bus_wr(2'd2, 32'h1234_5678, 4'h2);
    bus_rd("colora_be", 2'd2, 32'h0000_5600);

    // One-shot fade
    bus_wr(2'd2, 32'h0, 4'hF);
    bus_wr(2'd1, 32'h0003_0201, 4'hF);
    bus_wr(2'd3, 32'd3, 4'hF);
    push(24'h000000, 0); push(24'h010101, 4); push(24'h020201, 4); push(24'h030201, 4);
    bus_wr(2'd0, 32'h1, 4'hF);
    wait_drain("oneshot_drain", 100);
    repeat (6) @(negedge clk);
    bus_rd("oneshot_fin", 2'd0, 32'h0003_0101);
    chk("oneshot_novalid", {31'd0, lvalid}, 32'd0);
    bus_wr(2'd0, 32'h100, 4'hF);
    bus_rd("ctrl_cleared", 2'd0, 32'h0);

    // Backpressure on beat 010101
    push(24'h000000, 0); push(24'h010101, 0); push(24'h020201, 4); push(24'h030201, 4);
    bus_wr(2'd0, 32'h1, 4'hF);
    @(posedge clk); #1 lready = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_hold", {7'd0, lvalid, ldata}, {7'd0, 1'b1, 24'h010101});
    end
    @(posedge clk); #1 lready = 1'b1;
    wait_drain("bp_drain", 100);
    repeat (6) @(negedge clk);
    bus_rd("bp_fin", 2'd0, 32'h0003_0101);
    bus_wr(2'd0, 32'h100, 4'hF);

    // Breathe with IRQ
    bus_wr(2'd1, 32'h0002_0000, 4'hF);
    bus_wr(2'd3, 32'd0, 4'hF);
    push(24'h000000, 0); push(24'h010000, 2); push(24'h020000, 2);
    push(24'h010000, 2); push(24'h000000, 2); push(24'h010000, 2);
    bus_wr(2'd0, 32'h7, 4'hF);
    chk("br_irq_low", {31'd0, irq}, 32'd0);
    n = 0;
    while (!irq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("br_irq_delay", n, 6);
    bus_wr(2'd0, 32'h107, 4'hF);
    bus_rd("br_done_clr", 2'd0, 32'h0001_0007);
    @(negedge clk);
    chk("br_irq_drop", {31'd0, irq}, 32'd0);
    bus_rd("br_done_reset", 2'd0, 32'h0002_0107);
    bus_wr(2'd0, 32'h100, 4'hF);
    chk("br_stop_valid", {31'd0, lvalid}, 32'd0);
    wait_drain("br_drain", 5);
    bus_rd("br_idle", 2'd0, 32'h0);

    // Abort with a pending beat, then restart from COLOR_A
    bus_wr(2'd1, 32'h0005_0505, 4'hF);
    bus_wr(2'd3, 32'd3, 4'hF);
    push(24'h000000, 0);
    bus_wr(2'd0, 32'h1, 4'hF);
    @(posedge clk); #1 lready = 1'b0;
    wait_valid("ab_valid");
    chk("ab_pending", {8'd0, ldata}, 32'h0001_0101);
    bus_wr(2'd0, 32'h0, 4'hF);
    chk("ab_valid_drop", {31'd0, lvalid}, 32'd0);
    bus_rd("ab_idle", 2'd0, 32'h0);
    lready = 1'b1;
    push(24'h000000, 0);
    for (int k = 1; k <= 5; k++) push({8'(k), 8'(k), 8'(k)}, 4);
    bus_wr(2'd0, 32'h1, 4'hF);
    wait_drain("ab_drain", 200);
    repeat (6) @(negedge clk);
    bus_rd("ab_fin", 2'd0, 32'h0003_0101);
    bus_wr(2'd0, 32'h100, 4'hF);

    // Live destination change via a single byte lane
    bus_wr(2'd1, 32'h0010_1010, 4'hF);
    bus_wr(2'd3, 32'd0, 4'hF);
    push(24'h000000, 0);
    for (int k = 1; k <= 16; k++) push({8'(k), 8'(k), 8'(k)}, 2);
    for (int r = 17; r <= 255; r++) push({8'(r), 8'h10, 8'h10}, 2);
    bus_wr(2'd0, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    bus_wr(2'd1, 32'h00FF_0000, 4'h4);
    wait_drain("live_drain", 2000);
    repeat (6) @(negedge clk);
    bus_rd("live_fin", 2'd0, 32'h0003_0101);
    bus_rd("live_colorb", 2'd1, 32'h00FF_1010);
    chk("live_final", {8'd0, ldata}, 32'h00FF_1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
